ahb_bus_arbiter: RTL

//  Multi-manager AHB arbiter. Grants one of NUM_MASTERS requesters the shared address/control
//  bus using round-robin priority. Holds grant across fixed-length bursts and locked sequences.

---
 rtl/ahb_bus_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter: one-hot grant with burst and locked-sequence hold,
// plus registered HMASTER/HMASTLOCK for the downstream address/control mux.
module ahb_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned HMASTER_WIDTH  = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [NUM_MASTERS-1:0]   hbusreq,
  input  logic [NUM_MASTERS-1:0]   hlock,
  input  logic [1:0]               HTRANS,
  input  logic [2:0]               HBURST,
  input  logic                     HREADY,
  input  logic                     HRESP,
  output logic [NUM_MASTERS-1:0]   hgrant,
  output logic [HMASTER_WIDTH-1:0] HMASTER,
  output logic                     HMASTLOCK
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  localparam logic [HMASTER_WIDTH-1:0] DefIdx = HMASTER_WIDTH'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0]   DefOh  = NUM_MASTERS'(1) << DEFAULT_MASTER;

  typedef enum logic [1:0] {StPark, StGrant, StBurst, StLocked} state_e;

  state_e                   state_q, state_d;
  logic [3:0]               beat_q, beat_d, burst_len;
  logic [HMASTER_WIDTH-1:0] rr_q, rr_d, grant_idx_q, grant_idx_d, winner_idx;
  logic [HMASTER_WIDTH-1:0] hmaster_q;
  logic [NUM_MASTERS-1:0]   hgrant_q, hgrant_d, req_sh;
  logic                     hmastlock_q;
  logic                     any_req, nonseq_acc, seq_acc, fixed_burst, lock_req, arb_en;
  int unsigned              cand;

  assign nonseq_acc  = HREADY && (HTRANS == TransNonseq);
  assign seq_acc     = HREADY && (HTRANS == TransSeq);
  assign fixed_burst = (burst_len != 4'd0);
  assign any_req     = |hbusreq;
  // Lock is only honoured while the owner is still requesting.
  assign lock_req    = |(hlock & hbusreq & hgrant_q);

  always_comb begin
    case (HBURST)
      3'd2, 3'd3: burst_len = 4'd3;
      3'd4, 3'd5: burst_len = 4'd7;
      3'd6, 3'd7: burst_len = 4'd15;
      default:    burst_len = 4'd0;
    endcase
  end

  always_comb begin
    beat_d = beat_q;
    if (nonseq_acc) begin
      beat_d = burst_len;
    end else if (seq_acc && (beat_q != 4'd0)) begin
      beat_d = beat_q - 4'd1;
    end
    // An ERROR response terminates the burst even during its wait cycle.
    if (HRESP) begin
      beat_d = 4'd0;
    end
  end

  // Search from rr_q+NUM_MASTERS down to rr_q+1 so the nearest requester overwrites last.
  always_comb begin
    winner_idx = DefIdx;
    cand       = 0;
    req_sh     = '0;
    for (int unsigned k = NUM_MASTERS; k >= 1; k--) begin
      cand = 32'(rr_q) + k;
      if (cand >= NUM_MASTERS) begin
        cand = cand - NUM_MASTERS;
      end
      req_sh = hbusreq >> cand;
      if (req_sh[0]) begin
        winner_idx = HMASTER_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    case (state_q)
      StPark: begin
        if (HREADY) begin
          arb_en = 1'b1;
          if (any_req) begin
            state_d = StGrant;
          end
        end
      end
      StGrant: begin
        if (nonseq_acc && lock_req) begin
          state_d = StLocked;
        end else if (nonseq_acc && fixed_burst) begin
          state_d = StBurst;
        end else if (HREADY) begin
          arb_en  = 1'b1;
          state_d = any_req ? StGrant : StPark;
        end
      end
      StBurst: begin
        if (HREADY && ((beat_q == 4'd0) || (seq_acc && (beat_q == 4'd1)))) begin
          arb_en  = 1'b1;
          state_d = StGrant;
        end
      end
      StLocked: begin
        if (!lock_req && HREADY && ((HTRANS == TransIdle) || (HTRANS == TransNonseq))) begin
          state_d = (nonseq_acc && fixed_burst) ? StBurst : StGrant;
        end
      end
      default: state_d = StPark;
    endcase
  end

  always_comb begin
    grant_idx_d = grant_idx_q;
    rr_d        = rr_q;
    if (arb_en) begin
      grant_idx_d = winner_idx;
      if (any_req) begin
        rr_d = winner_idx;
      end
    end
    hgrant_d = NUM_MASTERS'(1) << grant_idx_d;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= StPark;
      beat_q      <= 4'd0;
      rr_q        <= DefIdx;
      grant_idx_q <= DefIdx;
      hgrant_q    <= DefOh;
      hmaster_q   <= DefIdx;
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      rr_q        <= rr_d;
      grant_idx_q <= grant_idx_d;
      hgrant_q    <= hgrant_d;
      if (HREADY) begin
        hmaster_q   <= grant_idx_q;
        hmastlock_q <= |(hlock & hgrant_q);
      end
    end
  end

  assign hgrant    = hgrant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

endmodule
